// File: rtl/wide_add_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : wide_add_sequencer (with adder_32bit)
// Description : Multi-precision add/subtract that reuses one 32-bit adder,
//               one word per cycle LSW first, with valid/ready on both sides.
// Revision    : 1.0 - initial release
//==============================================================================

module adder_32bit (
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic        C_in,
    output logic [31:0] sum,
    output logic        C_out
);
    assign {C_out, sum} = {1'b0, num1} + {1'b0, num2} + {32'd0, C_in};
endmodule

module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*WORDS-1:0]   op_a,
    input  logic [32*WORDS-1:0]   op_b,
    input  logic                  C_in,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WORDS-1:0]   result,
    output logic                  C_out,
    output logic                  overflow
);
    localparam int c_idx_w = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [31:0]          r_a   [WORDS];
    logic [31:0]          r_b   [WORDS];
    logic [31:0]          r_res [WORDS];
    logic                 r_sub;
    logic                 r_carry;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_cout;
    logic                 r_ovf;
    logic [31:0]          w_num1;
    logic [31:0]          w_num2;
    logic [31:0]          w_sum;
    logic                 w_cout;
    logic                 w_last;

    assign w_num1 = r_a[r_idx];
    assign w_num2 = r_sub ? ~r_b[r_idx] : r_b[r_idx];
    assign w_last = (r_idx == c_last);

    adder_32bit u_adder (
        .num1  (w_num1),
        .num2  (w_num2),
        .C_in  (r_carry),
        .sum   (w_sum),
        .C_out (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_next = ST_RUN;
            ST_RUN:  if (w_last)    w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    // Operand copies need no reset: they are only read while in RUN.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && in_valid) begin
            for (int i = 0; i < WORDS; i++) begin
                r_a[i] <= op_a[32*i +: 32];
                r_b[i] <= op_b[32*i +: 32];
            end
            r_sub <= sub;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                r_res[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_carry <= sub ? 1'b1 : C_in;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_res[r_idx] <= w_sum;
                    r_carry      <= w_cout;
                    if (w_last) begin
                        r_cout <= w_cout;
                        r_ovf  <= (w_num1[31] == w_num2[31]) && (w_sum[31] != w_num1[31]);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_result
        assign result[32*g +: 32] = r_res[g];
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign C_out     = r_cout;
    assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : tb_wide_add_sequencer
// Description : Directed self-checking bench for wide_add_sequencer (WORDS=4).
// Revision    : 1.0 - initial release
//==============================================================================

module tb_wide_add_sequencer;
    localparam int WORDS = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [32*WORDS-1:0] op_a;
    logic [32*WORDS-1:0] op_b;
    logic                C_in;
    logic                sub;
    logic                out_valid;
    logic                out_ready;
    logic [32*WORDS-1:0] result;
    logic                C_out;
    logic                overflow;

    int tests = 0;
    int fails = 0;

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .C_in      (C_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .C_out     (C_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one request and return once out_valid is seen (or the budget runs out).
    task automatic start_op(input logic [127:0] a, input logic [127:0] b,
                            input logic ci, input logic s, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        op_a = a; op_b = b; C_in = ci; sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op_a = '1; op_b = '1; C_in = 1'b0; sub = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [127:0] a, input logic [127:0] b,
                          input logic ci, input logic s, input logic [127:0] er,
                          input logic ec, input logic eo);
        int lat;
        start_op(a, b, ci, s, lat);
        chk({tag, "_lat"}, 128'(lat), 128'd4);
        chk({tag, "_res"}, result, er);
        chk({tag, "_cout"}, 128'(C_out), 128'(ec));
        chk({tag, "_ovf"}, 128'(overflow), 128'(eo));
        tick();
        chk({tag, "_rdy_after"}, 128'({in_ready, out_valid}), 128'b10);
    endtask

    initial begin
        int lat;
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op_a = '0; op_b = '0; C_in = 1'b0; sub = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_result", result, 128'd0);
        chk("rst_cout", 128'(C_out), 128'd0);
        chk("rst_ovf", 128'(overflow), 128'd0);

        run_op("ripple", 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0,
               128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0);
        run_op("wrap", {128{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0);
        run_op("cin", 128'd0, 128'd0, 1'b1, 1'b0, 128'd1, 1'b0, 1'b0);
        run_op("sub0m1", 128'd0, 128'd1, 1'b1, 1'b1, {128{1'b1}}, 1'b0, 1'b0);
        run_op("sovf", 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0,
               128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1);
        run_op("sub_big", 128'h00000005_00000000_00000000_00000000, 128'd1, 1'b0, 1'b1,
               128'h00000004_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1, 1'b0);

        // Backpressure: result 123 held while a new request (10+20) waits.
        out_ready = 1'b0;
        start_op(128'd100, 128'd23, 1'b0, 1'b0, lat);
        chk("bp_lat", 128'(lat), 128'd4);
        op_a = 128'd10; op_b = 128'd20; C_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 128'(out_valid), 128'd1);
            chk("bp_hold_res", result, 128'd123);
            chk("bp_hold_rdy", 128'(in_ready), 128'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_rdy", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_pending_lat", 128'(lat), 128'd4);
        chk("bp_pending_res", result, 128'd30);
        tick();

        // Reset mid-RUN aborts the operation without ever raising out_valid.
        op_a = 128'hFFFF; op_b = 128'h1234; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_result", result, 128'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("abort_no_valid", 128'(seen), 128'd0);
        run_op("post_abort", 128'd5, 128'd3, 1'b0, 1'b0, 128'd8, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
